// File: rtl/iomem_gpio_pkg.sv
// iomem_gpio_pkg: register map and helpers shared by the GPIO block
package iomem_gpio_pkg;
  localparam int OFFS_W = 6;
  localparam logic [OFFS_W-1:0] REG_DATA_OUT   = 6'h00;
  localparam logic [OFFS_W-1:0] REG_OE         = 6'h01;
  localparam logic [OFFS_W-1:0] REG_DATA_IN    = 6'h02;
  localparam logic [OFFS_W-1:0] REG_IRQ_EN     = 6'h03;
  localparam logic [OFFS_W-1:0] REG_IRQ_POL    = 6'h04;
  localparam logic [OFFS_W-1:0] REG_IRQ_STATUS = 6'h05;
  localparam logic [OFFS_W-1:0] REG_OUT_SET    = 6'h06;
  localparam logic [OFFS_W-1:0] REG_OUT_CLR    = 6'h07;
  function automatic logic [31:0] byte_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
endpackage

// File: rtl/iomem_gpio_sync_edge.sv
// gpio_sync_edge: input synchroniser chain with rise/fall pulse detection
module gpio_sync_edge #(
  parameter int NUM_GPIO    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_GPIO-1:0] pins_i,
  output logic [NUM_GPIO-1:0] sync_o,
  output logic [NUM_GPIO-1:0] rise_o,
  output logic [NUM_GPIO-1:0] fall_o
);
  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] sync_q;
  logic [NUM_GPIO-1:0] prev_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/iomem_gpio.sv
// iomem_gpio: picosoc iomem GPIO block with set/clear writes and edge interrupts
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int          NUM_GPIO    = 32,
  parameter logic [7:0]  ADDR_PREFIX = 8'h03,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);
  logic [NUM_GPIO-1:0] data_out_q, data_out_d, oe_q, oe_d, irq_en_q, irq_en_d;
  logic [NUM_GPIO-1:0] irq_pol_q, irq_pol_d, irq_status_q, irq_status_d;
  logic [NUM_GPIO-1:0] sync_in, rise, fall, m, wd;
  logic [31:0] rdata_q, rdata_d, mask32;
  logic ready_q, sel, wr, unused;
  logic [OFFS_W-1:0] offs;
  gpio_sync_edge #(.NUM_GPIO(NUM_GPIO), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset(reset), .pins_i(gpio_in), .sync_o(sync_in), .rise_o(rise), .fall_o(fall)
  );
  // the !ready_q term keeps a still-valid request from being accepted twice
  assign sel    = iomem_valid && !ready_q && iomem_addr[31:24] == ADDR_PREFIX;
  assign wr     = sel && |iomem_wstrb;
  assign offs   = iomem_addr[7:2];
  assign mask32 = byte_mask(iomem_wstrb);
  assign m      = mask32[NUM_GPIO-1:0];
  assign wd     = iomem_wdata[NUM_GPIO-1:0] & m;
  assign unused = ^{iomem_addr[23:8], iomem_addr[1:0], mask32, iomem_wdata};
  always_comb begin
    data_out_d   = !wr ? data_out_q :
                   offs == REG_DATA_OUT ? (data_out_q & ~m) | wd :
                   offs == REG_OUT_SET  ? data_out_q | wd :
                   offs == REG_OUT_CLR  ? data_out_q & ~wd : data_out_q;
    oe_d         = wr && offs == REG_OE      ? (oe_q & ~m) | wd      : oe_q;
    irq_en_d     = wr && offs == REG_IRQ_EN  ? (irq_en_q & ~m) | wd  : irq_en_q;
    irq_pol_d    = wr && offs == REG_IRQ_POL ? (irq_pol_q & ~m) | wd : irq_pol_q;
    // new edges are OR-ed in after the clear so a coincident edge survives
    irq_status_d = (irq_status_q & ~(wr && offs == REG_IRQ_STATUS ? wd : '0))
                   | (rise & ~irq_pol_q) | (fall & irq_pol_q);
    rdata_d      = offs == REG_DATA_OUT   ? 32'(data_out_q)   :
                   offs == REG_OE         ? 32'(oe_q)         :
                   offs == REG_DATA_IN    ? 32'(sync_in)      :
                   offs == REG_IRQ_EN     ? 32'(irq_en_q)     :
                   offs == REG_IRQ_POL    ? 32'(irq_pol_q)    :
                   offs == REG_IRQ_STATUS ? 32'(irq_status_q) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      oe_q         <= '0;
      irq_en_q     <= '0;
      irq_pol_q    <= '0;
      irq_status_q <= '0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      data_out_q   <= data_out_d;
      oe_q         <= oe_d;
      irq_en_q     <= irq_en_d;
      irq_pol_q    <= irq_pol_d;
      irq_status_q <= irq_status_d;
      ready_q      <= sel;
      rdata_q      <= sel ? rdata_d : '0;
    end
  end
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign gpio_out    = data_out_q;
  assign gpio_oe     = oe_q;
  assign irq         = |(irq_status_q & irq_en_q);
endmodule

// File: tb/tb_iomem_gpio.sv
// tb_iomem_gpio: directed self-checking bench for iomem_gpio (32-pin and 8-pin builds)
module tb_iomem_gpio;
  logic clk = 1'b0, reset, valid, ready, ready8, irq, irq8;
  logic [3:0] wstrb;
  logic [31:0] addr, wdata, rdata, rdata8, gin, gout, goe, r, r8;
  logic [7:0] gout8, goe8;
  int passes = 0, total = 0;

  always #5 clk = ~clk;

  iomem_gpio dut (
    .clk(clk), .reset(reset), .iomem_valid(valid), .iomem_ready(ready), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata), .gpio_in(gin),
    .gpio_out(gout), .gpio_oe(goe), .irq(irq)
  );
  iomem_gpio #(.NUM_GPIO(8)) dut8 (
    .clk(clk), .reset(reset), .iomem_valid(valid), .iomem_ready(ready8), .iomem_wstrb(wstrb),
    .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata8), .gpio_in(gin[7:0]),
    .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic acc(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output logic [31:0] rd8);
    @(negedge clk);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    #1 chk("ready_early", {31'b0, ready}, 32'd0);
    @(posedge clk);
    #1 rd = rdata; rd8 = rdata8;
    chk("ready_pulse", {31'b0, ready}, 32'd1);
    valid = 1'b0; wstrb = 4'h0;
    @(posedge clk);
    #1 chk("ready_drop", {31'b0, ready}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; wstrb = '0; addr = '0; wdata = '0; gin = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    // reset state
    chk("rst_gpio_out", gout, 32'h0);
    chk("rst_gpio_oe", goe, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    acc(32'h0300_0000, 4'h0, 32'h0, r, r8);
    chk("rst_read", r, 32'h0);
    // byte strobes, set, clear, ignored address bits
    acc(32'h0300_0000, 4'b0101, 32'h1234_5678, r, r8);
    chk("strobe_out", gout, 32'h0034_0078);
    acc(32'h0300_0018, 4'hF, 32'hFF00_0000, r, r8);
    chk("set_out", gout, 32'hFF34_0078);
    acc(32'h0300_001C, 4'hF, 32'h0000_0078, r, r8);
    chk("clr_out", gout, 32'hFF34_0000);
    acc(32'h03AB_CD03, 4'h0, 32'h0, r, r8);
    chk("read_alias", r, 32'hFF34_0000);
    acc(32'h0300_0018, 4'h0, 32'h0, r, r8);
    chk("read_set_zero", r, 32'h0);
    acc(32'h0300_0004, 4'hF, 32'h0000_FFFF, r, r8);
    chk("oe_pins", goe, 32'h0000_FFFF);
    acc(32'h0300_0004, 4'hF, 32'h0000_0001, r, r8);
    chk("read_before_write", r, 32'h0000_FFFF);
    acc(32'h0300_0020, 4'hF, 32'hFFFF_FFFF, r, r8);
    chk("unmapped_read", r, 32'h0);
    chk("unmapped_no_effect", gout, 32'hFF34_0000);
    // input synchroniser latency
    acc(32'h0300_0008, 4'h0, 32'h0, r, r8);
    chk("din_idle", r, 32'h0);
    @(negedge clk) gin[5] = 1'b1;
    @(posedge clk);
    acc(32'h0300_0008, 4'h0, 32'h0, r, r8);
    chk("din_too_early", r, 32'h0);
    acc(32'h0300_0008, 4'h0, 32'h0, r, r8);
    chk("din_synced", r, 32'h0000_0020);
    // foreign prefix never gets ready
    @(negedge clk);
    valid = 1'b1; addr = 32'h0400_0000; wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 chk("foreign_no_ready", {31'b0, ready}, 32'd0);
    end
    valid = 1'b0;
    acc(32'h0300_0014, 4'hF, 32'hFFFF_FFFF, r, r8);
    // rising-edge interrupt
    acc(32'h0300_000C, 4'hF, 32'h0000_0001, r, r8);
    @(negedge clk) gin[0] = 1'b1;
    repeat (4) @(posedge clk);
    acc(32'h0300_0014, 4'h0, 32'h0, r, r8);
    chk("rise_status", r, 32'h0000_0001);
    chk("rise_irq", {31'b0, irq}, 32'd1);
    acc(32'h0300_0014, 4'hF, 32'h0000_0001, r, r8);
    acc(32'h0300_0014, 4'h0, 32'h0, r, r8);
    chk("w1c_status", r, 32'h0);
    chk("w1c_irq", {31'b0, irq}, 32'd0);
    // falling-edge interrupt while disabled
    acc(32'h0300_0010, 4'hF, 32'h0000_0008, r, r8);
    @(negedge clk) gin[3] = 1'b1;
    repeat (4) @(posedge clk);
    acc(32'h0300_0014, 4'h0, 32'h0, r, r8);
    chk("fall_pol_ignores_rise", r, 32'h0);
    @(negedge clk) gin[3] = 1'b0;
    repeat (4) @(posedge clk);
    acc(32'h0300_0014, 4'h0, 32'h0, r, r8);
    chk("fall_status", r, 32'h0000_0008);
    chk("fall_irq_masked", {31'b0, irq}, 32'd0);
    acc(32'h0300_000C, 4'hF, 32'h0000_0009, r, r8);
    chk("fall_irq_enabled", {31'b0, irq}, 32'd1);
    acc(32'h0300_0014, 4'hF, 32'h0000_0008, r, r8);
    chk("fall_cleared_irq", {31'b0, irq}, 32'd0);
    // edge set beats simultaneous W1C
    @(negedge clk) gin[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) gin[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    acc(32'h0300_0014, 4'hF, 32'h0000_0001, r, r8);
    acc(32'h0300_0014, 4'h0, 32'h0, r, r8);
    chk("set_wins", r, 32'h0000_0001);
    // narrow build drops upper bits
    acc(32'h0300_0004, 4'hF, 32'hFFFF_FFFF, r, r8);
    acc(32'h0300_0004, 4'h0, 32'h0, r, r8);
    chk("oe_32", r, 32'hFFFF_FFFF);
    chk("oe_8", r8, 32'h0000_00FF);
    chk("oe8_pins", {24'b0, goe8}, 32'h0000_00FF);
    // reset drops a pending access
    @(negedge clk);
    valid = 1'b1; addr = 32'h0300_0000; wstrb = 4'h0; reset = 1'b1;
    @(posedge clk);
    #1 chk("reset_no_ready", {31'b0, ready}, 32'd0);
    valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    chk("reset_out", gout, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/iomem_gpio.md
Name: iomem_gpio

Overview:
Parametrised GPIO peripheral on the picosoc iomem bus. Replaces the single in-wrapper 32-bit output register with a multi-register block:
- per-pin output and output-enable
- synchronised inputs
- atomic set/clear writes
- per-pin edge interrupts with one aggregated irq line for picosoc irq_5..7

It decodes one iomem address window and sits beside other iomem slaves in the wrapper.

Parameters:
NUM_GPIO, 32, number of pins, 1..32; register bits at and above NUM_GPIO read 0 and ignore writes.
ADDR_PREFIX, 8'h03, value of iomem_addr[31:24] selecting this block.
SYNC_STAGES, 2, input synchroniser depth, 2..4.

Ports:
clk  in  1  system clock; the block uses this single clock.
reset  in  1  synchronous, active-high reset.
iomem_valid  in  1  bus request valid.
iomem_ready  out  1  one-cycle completion pulse.
iomem_wstrb  in  4  byte write strobes; 0 means read.
iomem_addr  in  32  byte address.
iomem_wdata  in  32  write data.
iomem_rdata  out  32  read data, valid while iomem_ready is high.
gpio_in  in  NUM_GPIO  asynchronous pad inputs.
gpio_out  out  NUM_GPIO  pad output values.
gpio_oe  out  NUM_GPIO  pad output enables, 1 = drive.
irq  out  1  level interrupt = |(IRQ_STATUS & IRQ_EN).

Behaviour:
- Reset (synchronous, reset=1 at clk edge): all registers 0, synchroniser flops 0, iomem_ready=0, iomem_rdata=0, gpio_out=0, gpio_oe=0, irq=0.
- Select condition: iomem_valid && !iomem_ready && addr[31:24]==ADDR_PREFIX.
  - If selected: iomem_ready=1 on the next cycle, for exactly one cycle. iomem_rdata is registered in the same cycle. A write takes effect on the same edge.
  - Back-to-back transactions: at most one every 2 cycles.
  - Unselected addresses never produce ready.
- Register offsets use addr[7:2]; addr[23:8] and addr[1:0] are ignored. wstrb[n] enables byte n.
  - 0x00 DATA_OUT: RW.
  - 0x04 OE: RW.
  - 0x08 DATA_IN: RO, synchronised pins.
  - 0x0C IRQ_EN: RW.
  - 0x10 IRQ_POL: RW; bit=0 rising edge, bit=1 falling edge.
  - 0x14 IRQ_STATUS: read; write-1-to-clear.
  - 0x18 OUT_SET: WO; DATA_OUT |= wdata; reads 0.
  - 0x1C OUT_CLR: WO; DATA_OUT &= ~wdata; reads 0.
  - Other offsets: read 0, writes ignored, ready still pulses.
- Read value: a read returns the register value before any write in the same access. Reads have no side effects.
- Input synchroniser: a pin change appears in DATA_IN SYNC_STAGES cycles later.
- Edge detection: compares the last synchroniser stage with a one-cycle-delayed copy. A detected edge of the selected polarity sets its IRQ_STATUS bit on the following edge.
  - Edges latch even when IRQ_EN=0.
  - irq is combinational from the status and enable registers.
- Simultaneous events:
  - Edge set and W1C on the same status bit in the same cycle: set wins, bit stays 1.
  - Changing IRQ_POL does not by itself create an edge.
- Outputs: gpio_out=DATA_OUT and gpio_oe=OE, driven directly from the registers.
- Reset mid-transaction: the pending access is dropped and ready is not issued. The master re-issues the access after reset.

Decomposition:
Shared package iomem_gpio_pkg holds:
- register offset localparams REG_DATA_OUT..REG_OUT_CLR
- the address-width constant for offset decode

One sub-module, gpio_sync_edge (parameters NUM_GPIO, SYNC_STAGES), contains:
- the synchroniser chain
- the delayed copy
- rise and fall pulse vectors

The top level holds the bus decode, registers and interrupt logic.

Test Plan:
1. After reset: read 0x03000000 -> ready exactly one cycle after valid, rdata=0; gpio_out=0, gpio_oe=0, irq=0.
2. Byte strobes: write 0x12345678 to DATA_OUT with wstrb=4'b0101 -> gpio_out=0x00340078. Then write OUT_SET 0xFF000000 then OUT_CLR 0x00000078 -> gpio_out=0xFF340000.
3. Input latency: gpio_in[5] 0->1 -> DATA_IN bit5 reads 1 no earlier than 2 cycles after the change with SYNC_STAGES=2. An address with prefix 0x04 -> ready never asserted.
4. Interrupt, rising edge: IRQ_EN=0x1, IRQ_POL=0, rising edge on gpio_in[0] -> IRQ_STATUS=0x1 and irq=1. Writing 0x1 to IRQ_STATUS -> status=0, irq=0.
5. Interrupt, falling edge: IRQ_POL bit3=1, falling edge on pin 3 while IRQ_EN=0 -> status bit3=1, irq=0. Set IRQ_EN bit3 -> irq=1.
6. Simultaneous set/clear: W1C of bit 0 in the same cycle as a new rising edge -> status bit0 remains 1. NUM_GPIO=8 build: write 0xFFFFFFFF to OE -> reads 0x000000FF.
